// File: rtl/turbosound_pkg.sv
// Shared types, widths and helpers for the TurboSound output mixer.
package turbosound_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_DCL  = 3'd2,
    ST_DCR  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam logic [1:0] STEREO_MONO = 2'd0;
  localparam logic [1:0] STEREO_ABC  = 2'd1;
  localparam logic [1:0] STEREO_ACB  = 2'd2;

  localparam int PSG_W  = 8;
  localparam int FM_W   = 11;
  localparam int SIDE_W = 10;
  localparam int TERM_W = 18;
  localparam int Y_W    = 30;
  localparam int FRAC   = 8;
  localparam int OUT_W  = 16;
  localparam int PSG_SH = 4;
  localparam int FM_SH  = 3;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // Per-chip channel snapshot; fm is two's complement.
  typedef struct packed {
    logic [PSG_W-1:0] a;
    logic [PSG_W-1:0] b;
    logic [PSG_W-1:0] c;
    logic [FM_W-1:0]  fm;
  } chip_snap_t;

  // PSG level sum for one side; mode 3 falls through to the ABC layout.
  function automatic logic [SIDE_W-1:0] side_sum(input logic [1:0]       mode,
                                                 input logic             right,
                                                 input logic [PSG_W-1:0] a,
                                                 input logic [PSG_W-1:0] b,
                                                 input logic [PSG_W-1:0] c);
    logic [SIDE_W-1:0] ea, eb, ec;
    ea = SIDE_W'(a);
    eb = SIDE_W'(b);
    ec = SIDE_W'(c);
    case (mode)
      STEREO_MONO: side_sum = ea + eb + ec;
      STEREO_ACB:  side_sum = right ? (eb << 1) + ec : (ea << 1) + ec;
      default:     side_sum = right ? (ec << 1) + eb : (ea << 1) + eb;
    endcase
  endfunction

endpackage

// File: rtl/turbosound_mixer_dc_step.sv
// dc_step: one combinational DC-blocker update plus output saturation.
// Shared by both stereo sides; the caller muxes in the side's state.
module dc_step
  import turbosound_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic signed [TERM_W-1:0] x_i,
  input  logic signed [TERM_W-1:0] x_prev_i,
  input  logic signed [Y_W-1:0]    y_i,
  input  logic                     en_i,
  output logic signed [Y_W-1:0]    y_o,
  output logic signed [OUT_W-1:0]  out_o
);

  localparam int DW = TERM_W + 1;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [Y_W-1:0] v);
    if (v > $signed(Y_W'(SAT_MAX)))      sat_out = OUT_W'(SAT_MAX);
    else if (v < $signed(Y_W'(SAT_MIN))) sat_out = OUT_W'(SAT_MIN);
    else                                 sat_out = v[OUT_W-1:0];
  endfunction

  logic signed [DW-1:0]  diff;
  logic signed [Y_W-1:0] diff_sh;
  logic signed [Y_W-1:0] leak;
  logic signed [Y_W-1:0] y_int;

  // Leaky integrator of input differences; bypass reloads y from x.
  always_comb begin
    diff    = DW'(x_i) - DW'(x_prev_i);
    diff_sh = Y_W'(diff) <<< FRAC;
    leak    = y_i >>> DC_SHIFT;
    if (en_i) y_o = y_i - leak + diff_sh;
    else      y_o = Y_W'(x_i) <<< FRAC;
    y_int = y_o >>> FRAC;
    out_o = sat_out(y_int);
  end

endmodule

// File: rtl/turbosound_mixer.sv
// turbosound_mixer: snapshots both ym2203 chips on a sample strobe, mixes
// PSG and FM into left/right through one shared accumulator, then runs a
// shared DC blocker per side and registers saturated 16-bit outputs.
module turbosound_mixer
  import turbosound_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CE_SAMPLE,
  input  logic [1:0]              STEREO,
  input  logic [1:0]              CHIP_ENA,
  input  logic                    DCF_EN,
  input  logic [PSG_W-1:0]        PSG0_A,
  input  logic [PSG_W-1:0]        PSG0_B,
  input  logic [PSG_W-1:0]        PSG0_C,
  input  logic [PSG_W-1:0]        PSG1_A,
  input  logic [PSG_W-1:0]        PSG1_B,
  input  logic [PSG_W-1:0]        PSG1_C,
  input  logic [FM_W-1:0]         FM0,
  input  logic [FM_W-1:0]         FM1,
  output logic signed [OUT_W-1:0] OUT_L,
  output logic signed [OUT_W-1:0] OUT_R,
  output logic                    OUT_VALID,
  output logic                    OVERRUN
);

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;

  chip_snap_t snap_q [2];
  logic [1:0] mode_q;
  logic [1:0] ena_q;
  logic       dcf_q;

  logic snap_en, acc_en, acc_clr, save_xl, dc_left, dc_right, out_en;

  logic                     chip_sel, fm_sel, right_sel;
  logic [SIDE_W-1:0]        side;
  logic signed [TERM_W-1:0] term, acc_base, acc_d, acc_q, xl_q;
  logic signed [TERM_W-1:0] xprev_l_q, xprev_r_q;
  logic signed [Y_W-1:0]    y_l_q, y_r_q;
  logic signed [OUT_W-1:0]  res_l_q, res_r_q;

  logic signed [TERM_W-1:0] dc_x, dc_xp;
  logic signed [Y_W-1:0]    dc_yin, dc_y;
  logic signed [OUT_W-1:0]  dc_out;

  // State and step counter; reset abandons any sample in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Sequence: IDLE -> 8 SUM steps -> DCL -> DCR -> OUT -> IDLE.
  always_comb begin
    state_d = state_q;
    step_d  = '0;
    case (state_q)
      ST_IDLE: if (CE_SAMPLE) state_d = ST_SUM;
      ST_SUM: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) state_d = ST_DCL;
      end
      ST_DCL:  state_d = ST_DCR;
      ST_DCR:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    snap_en  = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    save_xl  = 1'b0;
    dc_left  = 1'b0;
    dc_right = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      ST_IDLE: snap_en = CE_SAMPLE;
      ST_SUM: begin
        acc_en  = 1'b1;
        acc_clr = (step_q[1:0] == 2'd0);
        save_xl = (step_q == 3'd4);
      end
      ST_DCL:  dc_left  = 1'b1;
      ST_DCR:  dc_right = 1'b1;
      ST_OUT:  out_en   = 1'b1;
      default: ;
    endcase
  end

  // Term select: step bit2 = side, bit1 = chip, bit0 = FM vs PSG.
  always_comb begin
    right_sel = step_q[2];
    chip_sel  = step_q[1];
    fm_sel    = step_q[0];
    side      = side_sum(mode_q, right_sel, snap_q[chip_sel].a,
                         snap_q[chip_sel].b, snap_q[chip_sel].c);
    if (!ena_q[chip_sel])
      term = '0;
    else if (fm_sel)
      term = TERM_W'($signed(snap_q[chip_sel].fm)) <<< FM_SH;
    else
      term = $signed(TERM_W'(side) << PSG_SH);
    acc_base = acc_clr ? TERM_W'(0) : acc_q;
    acc_d    = acc_base + term;
  end

  // Input snapshot, captured only when a strobe is accepted.
  always_ff @(posedge CLK) begin
    if (snap_en) begin
      snap_q[0] <= {PSG0_A, PSG0_B, PSG0_C, FM0};
      snap_q[1] <= {PSG1_A, PSG1_B, PSG1_C, FM1};
      mode_q    <= STEREO;
      ena_q     <= CHIP_ENA;
      dcf_q     <= DCF_EN;
    end
  end

  // Shared filter inputs: left uses the saved x_l, right the live accumulator.
  always_comb begin
    dc_x   = dc_right ? acc_q     : xl_q;
    dc_xp  = dc_right ? xprev_r_q : xprev_l_q;
    dc_yin = dc_right ? y_r_q     : y_l_q;
  end

  dc_step #(
    .DC_SHIFT(DC_SHIFT)
  ) u_dc_step (
    .x_i     (dc_x),
    .x_prev_i(dc_xp),
    .y_i     (dc_yin),
    .en_i    (dcf_q),
    .y_o     (dc_y),
    .out_o   (dc_out)
  );

  // Accumulator, left-sum holding register and per-side filter state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q     <= '0;
      xl_q      <= '0;
      xprev_l_q <= '0;
      xprev_r_q <= '0;
      y_l_q     <= '0;
      y_r_q     <= '0;
    end else begin
      if (acc_en)  acc_q <= acc_d;
      if (save_xl) xl_q  <= acc_q;
      if (dc_left) begin
        y_l_q     <= dc_y;
        xprev_l_q <= xl_q;
      end
      if (dc_right) begin
        y_r_q     <= dc_y;
        xprev_r_q <= acc_q;
      end
    end
  end

  // Saturated side results held until both sides are ready.
  always_ff @(posedge CLK) begin
    if (dc_left)  res_l_q <= dc_out;
    if (dc_right) res_r_q <= dc_out;
  end

  // Registered outputs, valid pulse and overrun flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_L     <= '0;
      OUT_R     <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_VALID <= out_en;
      OVERRUN   <= CE_SAMPLE && (state_q != ST_IDLE);
      if (out_en) begin
        OUT_L <= res_l_q;
        OUT_R <= res_r_q;
      end
    end
  end

endmodule

// File: tb/tb_turbosound_mixer.sv
// Bench for turbosound_mixer: fixed vectors with hand-derived results,
// overrun / reset / DC-blocker sequences, and randomized samples against
// an arithmetic reference model of the mixing and filtering rules.
module tb_turbosound_mixer;
  import turbosound_pkg::*;

  localparam int DCS = 10;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CE_SAMPLE;
  logic [1:0]        STEREO;
  logic [1:0]        CHIP_ENA;
  logic              DCF_EN;
  logic [7:0]        PSG0_A, PSG0_B, PSG0_C, PSG1_A, PSG1_B, PSG1_C;
  logic [10:0]       FM0, FM1;
  logic signed [15:0] OUT_L, OUT_R;
  logic              OUT_VALID;
  logic              OVERRUN;

  turbosound_mixer #(.DC_SHIFT(DCS)) dut (
    .CLK(CLK), .RESET(RESET), .CE_SAMPLE(CE_SAMPLE), .STEREO(STEREO),
    .CHIP_ENA(CHIP_ENA), .DCF_EN(DCF_EN),
    .PSG0_A(PSG0_A), .PSG0_B(PSG0_B), .PSG0_C(PSG0_C),
    .PSG1_A(PSG1_A), .PSG1_B(PSG1_B), .PSG1_C(PSG1_C),
    .FM0(FM0), .FM1(FM1),
    .OUT_L(OUT_L), .OUT_R(OUT_R), .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  stereo;
    logic [1:0]  ena;
    logic        dcf;
    logic [7:0]  a0, b0, c0, a1, b1, c1;
    logic [10:0] fm0, fm1;
  } vin_t;

  typedef struct {
    string name;
    vin_t  in;
    int    el;
    int    er;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  longint m_y [2];
  int     m_xp [2];
  vec_t   tbl [11];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vin_t mkv(input logic [1:0] st, input logic [1:0] en, input logic dcf,
                               input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] c0,
                               input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] c1,
                               input logic [10:0] f0, input logic [10:0] f1);
    vin_t v;
    v.stereo = st; v.ena = en; v.dcf = dcf;
    v.a0 = a0; v.b0 = b0; v.c0 = c0; v.a1 = a1; v.b1 = b1; v.c1 = c1;
    v.fm0 = f0; v.fm1 = f1;
    return v;
  endfunction

  task automatic set_vec(input int i, input string n, input vin_t v, input int el, input int er);
    tbl[i].name = n; tbl[i].in = v; tbl[i].el = el; tbl[i].er = er;
  endtask

  task automatic drive(input vin_t v);
    STEREO = v.stereo; CHIP_ENA = v.ena; DCF_EN = v.dcf;
    PSG0_A = v.a0; PSG0_B = v.b0; PSG0_C = v.c0;
    PSG1_A = v.a1; PSG1_B = v.b1; PSG1_C = v.c1;
    FM0 = v.fm0; FM1 = v.fm1;
  endtask

  function automatic vin_t rnd_vin();
    vin_t v;
    v.stereo = 2'($urandom); v.ena = 2'($urandom); v.dcf = 1'($urandom);
    v.a0 = 8'($urandom); v.b0 = 8'($urandom); v.c0 = 8'($urandom);
    v.a1 = 8'($urandom); v.b1 = 8'($urandom); v.c1 = 8'($urandom);
    v.fm0 = 11'($urandom); v.fm1 = 11'($urandom);
    return v;
  endfunction

  // Stereo layout rule: mono A+B+C, ACB 2A+C / 2B+C, otherwise 2A+B / 2C+B.
  function automatic int psg_side(input int mode, input int right, input int a, input int b, input int c);
    if (mode == 0) return a + b + c;
    if (mode == 2) return (right != 0) ? 2 * b + c : 2 * a + c;
    return (right != 0) ? 2 * c + b : 2 * a + b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_y[s]  = 0;
      m_xp[s] = 0;
    end
  endtask

  task automatic model_step(input vin_t v, output int el, output int er);
    int     f0, f1, x;
    longint o;
    int     res [2];
    f0 = int'($signed(v.fm0));
    f1 = int'($signed(v.fm1));
    for (int s = 0; s < 2; s++) begin
      x = 0;
      if (v.ena[0]) x += psg_side(int'(v.stereo), s, int'(v.a0), int'(v.b0), int'(v.c0)) * 16 + f0 * 8;
      if (v.ena[1]) x += psg_side(int'(v.stereo), s, int'(v.a1), int'(v.b1), int'(v.c1)) * 16 + f1 * 8;
      if (v.dcf) m_y[s] = m_y[s] - (m_y[s] >>> DCS) + longint'(x - m_xp[s]) * 256;
      else       m_y[s] = longint'(x) * 256;
      m_xp[s] = x;
      o = m_y[s] >>> 8;
      if (o > 32767) o = 32767;
      if (o < -32768) o = -32768;
      res[s] = int'(o);
    end
    el = res[0];
    er = res[1];
  endtask

  // Strobe one sample, scramble inputs, wait (bounded) for the valid pulse.
  task automatic run_sample(input string name, input vin_t v, input int gap, input int el, input int er);
    int lat, ov;
    bit found;
    repeat (gap) @(negedge CLK);
    drive(v);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    drive(rnd_vin());
    lat = 0; ov = 0; found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge CLK);
      ov += int'(OVERRUN);
      if (OUT_VALID) begin
        found = 1'b1;
        lat   = c;
      end
    end
    chk({name, "_latency"}, lat, 11);
    chk({name, "_L"}, OUT_L, el);
    chk({name, "_R"}, OUT_R, er);
    chk({name, "_no_overrun"}, ov, 0);
    @(negedge CLK);
    chk({name, "_pulse_len"}, OUT_VALID, 0);
    chk({name, "_hold_L"}, OUT_L, el);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vin_t v, v2;
    int   el, er, ov, nv, vc, vl, vr, prev;

    set_vec(0,  "abc_a0",      mkv(STEREO_ABC, 2'b11, 0, 255, 0, 0, 0, 0, 0, 0, 0), 8160, 0);
    set_vec(1,  "mono_fm0",    mkv(STEREO_MONO, 2'b11, 0, 0, 0, 0, 0, 0, 0, 11'h400, 0), -8192, -8192);
    set_vec(2,  "sat_all",     mkv(STEREO_ABC, 2'b11, 0, 255, 255, 255, 255, 255, 255, 11'h3FF, 11'h3FF), 32767, 32767);
    set_vec(3,  "mute_chip1",  mkv(STEREO_ABC, 2'b01, 0, 255, 255, 255, 255, 255, 255, 11'h3FF, 11'h3FF), 20424, 20424);
    set_vec(4,  "acb_b1",      mkv(STEREO_ACB, 2'b11, 0, 0, 0, 0, 0, 200, 0, 0, 0), 0, 6400);
    set_vec(5,  "mono_mix",    mkv(STEREO_MONO, 2'b11, 0, 10, 20, 30, 0, 0, 0, 0, 0), 960, 960);
    set_vec(6,  "fm1_neg1",    mkv(STEREO_MONO, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 11'h7FF), -8, -8);
    set_vec(7,  "mute_all",    mkv(STEREO_ABC, 2'b00, 0, 255, 255, 255, 255, 255, 255, 11'h3FF, 11'h3FF), 0, 0);
    set_vec(8,  "mode3_c1",    mkv(2'd3, 2'b11, 0, 0, 0, 0, 0, 0, 255, 0, 0), 0, 8160);
    set_vec(9,  "mute_chip0",  mkv(STEREO_ABC, 2'b10, 0, 255, 0, 0, 0, 0, 0, 0, 11'h3FF), 8184, 8184);
    set_vec(10, "acb_c0_b0",   mkv(STEREO_ACB, 2'b11, 0, 0, 50, 100, 0, 0, 0, 0, 0), 1600, 3200);

    RESET = 1'b1;
    CE_SAMPLE = 1'b0;
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge CLK);
    chk("reset_L", OUT_L, 0);
    chk("reset_R", OUT_R, 0);
    chk("reset_valid", OUT_VALID, 0);
    chk("reset_overrun", OVERRUN, 0);
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);

    // Fixed vectors (bypass mode, so each result stands alone).
    for (int i = 0; i < 11; i++) begin
      model_step(tbl[i].in, el, er);
      run_sample(tbl[i].name, tbl[i].in, 0, tbl[i].el, tbl[i].er);
    end

    // Second strobe 5 CLK after the first is dropped; +12 CLK is accepted.
    v  = mkv(STEREO_ABC, 2'b11, 0, 255, 0, 0, 0, 0, 0, 0, 0);
    v2 = mkv(STEREO_MONO, 2'b11, 0, 0, 0, 0, 0, 0, 0, 11'h400, 11'h400);
    model_step(v, el, er);
    drive(v);
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    ov = 0; nv = 0; vc = 0; vl = 0; vr = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 5) begin
        drive(v2);
        CE_SAMPLE = 1'b1;
      end
      @(negedge CLK);
      CE_SAMPLE = 1'b0;
      ov += int'(OVERRUN);
      if (OUT_VALID) begin
        nv++;
        vc = c;
        vl = int'(OUT_L);
        vr = int'(OUT_R);
      end
    end
    chk("ovr_pulses", ov, 1);
    chk("ovr_valid_count", nv, 1);
    chk("ovr_latency", vc, 11);
    chk("ovr_L", vl, el);
    chk("ovr_R", vr, er);
    v = mkv(STEREO_MONO, 2'b11, 0, 0, 0, 0, 0, 100, 0, 0, 0);
    model_step(v, el, er);
    run_sample("accept_at_12", v, 0, el, er);

    // Reset in the middle of the SUM phase.
    drive(mkv(STEREO_ABC, 2'b11, 0, 0, 0, 0, 255, 255, 255, 0, 0));
    CE_SAMPLE = 1'b1;
    @(negedge CLK);
    CE_SAMPLE = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midsum_reset_L", OUT_L, 0);
    chk("midsum_reset_R", OUT_R, 0);
    chk("midsum_reset_valid", OUT_VALID, 0);
    nv = 0;
    repeat (16) begin
      @(negedge CLK);
      nv += int'(OUT_VALID);
    end
    chk("midsum_no_pulse", nv, 0);
    model_reset();

    // DC blocker on a constant input, strobes every 64 CLK from reset.
    v = mkv(STEREO_ABC, 2'b11, 1, 255, 0, 0, 0, 0, 0, 0, 0);
    prev = 32768;
    for (int k = 0; k < 8; k++) begin
      model_step(v, el, er);
      run_sample($sformatf("dc%0d", k), v, 51, el, er);
      if (k == 0) chk("dc_first", OUT_L, 8160);
      if (k == 1) chk("dc_second", OUT_L, 8152);
      chk($sformatf("dc%0d_decreasing", k), (int'(OUT_L) < prev) ? 1 : 0, 1);
      chk($sformatf("dc%0d_positive", k), (OUT_L > 0) ? 1 : 0, 1);
      chk($sformatf("dc%0d_R_zero", k), OUT_R, 0);
      prev = int'(OUT_L);
    end

    // Randomized samples, filter mostly enabled, varying spacing.
    for (int n = 0; n < 40; n++) begin
      v = rnd_vin();
      v.dcf = ($urandom_range(0, 3) != 0);
      model_step(v, el, er);
      run_sample($sformatf("rnd%0d", n), v, int'($urandom_range(0, 8)), el, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbosound_mixer.md
# turbosound_mixer

Downstream audio stage for the TurboSound pair of ym2203 wrappers. It snapshots both chips' PSG channels A/B/C and FM output on each sample strobe, then forms left and right sums for the selected stereo mode. The sums pass through a DC-blocking high-pass filter and are saturated to signed 16-bit for the audio output path. The arithmetic runs through one time-multiplexed accumulator under a small FSM.

## Interface
Parameters:
- DC_SHIFT, 10: DC-blocker pole shift; leak per sample is y>>>DC_SHIFT.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- CE_SAMPLE  in  1  one-CLK sample strobe; minimum spacing 12 CLK.
- STEREO  in  2  0 mono, 1 ABC, 2 ACB, 3 treated as ABC.
- CHIP_ENA  in  2  bit n = 0 mutes chip n.
- DCF_EN  in  1  1 = DC blocker active, 0 = bypass (y = x).
- PSG0_A, PSG0_B, PSG0_C, PSG1_A, PSG1_B, PSG1_C  in  8 each  unsigned PSG levels.
- FM0, FM1  in  11 each  signed two's-complement FM samples.
- OUT_L, OUT_R  out  16 each  signed mixed output.
- OUT_VALID  out  1  one-CLK pulse when OUT_L/OUT_R update.
- OVERRUN  out  1  one-CLK pulse when a strobe arrives while the block is busy.

## Operation
- **Snapshot.** On CE_SAMPLE in IDLE, register all channel inputs plus STEREO, CHIP_ENA and DCF_EN. Later input changes do not affect the sample in flight.
- **PSG side sums** (unsigned 10-bit, max 765):
  - ABC: L = 2A+B, R = 2C+B.
  - ACB: L = 2A+C, R = 2B+C.
  - mono: L = R = A+B+C.
- **Terms.**
  - PSG term = side_sum<<4 (0..12240).
  - FM term = sign-extended FM<<3 (-8192..8184).
  - A muted chip contributes 0 to both terms.
- **Mix value.** x_side is the signed 18-bit sum of 4 terms: chip0 PSG, chip0 FM, chip1 PSG, chip1 FM.
- **DC blocker**, per side, state x_prev (18-bit signed) and y (30-bit signed, 8 fractional bits):
  - y' = y − (y>>>DC_SHIFT) + ((x − x_prev)<<8); then x_prev' = x.
  - Bypass: y' = x<<8, and x_prev is still updated.
- **Output.** y'>>>8, saturated to [-32768, 32767].
- **FSM states:**
  - IDLE → SUM on strobe.
  - SUM, steps 0..7: steps 0–3 accumulate the left terms, steps 4–7 the right terms.
  - DCL, then DCR.
  - OUT → IDLE.
- **Strobe while busy:** CE_SAMPLE in any state other than IDLE is dropped and OVERRUN pulses in the following cycle. A strobe coincident with the OUT state is also dropped.
- **Reset:** RESET in any state forces IDLE. It clears the accumulators, x_prev, y, OUT_L, OUT_R, OUT_VALID and OVERRUN; the in-flight sample is discarded.

## Timing
- Strobe sampled at edge 0 (snapshot, IDLE→SUM).
- SUM steps occupy edges 1–8; DCL at edge 9; DCR at edge 10.
- Edge 11: OUT_L/OUT_R registered and OUT_VALID high for that one cycle.
- The block returns to IDLE at edge 12, so a strobe exactly 12 CLK after the previous one is accepted.
- All outputs are registered.
- Reset values: OUT_L = 0, OUT_R = 0, OUT_VALID = 0, OVERRUN = 0.
- OUT_L and OUT_R hold their values between valid pulses.

## Structure
- **Package `turbosound_pkg`:**
  - FSM state enum.
  - Stereo-mode constants (MONO/ABC/ACB).
  - Widths: TERM_W = 18, Y_W = 30, FRAC = 8.
  - Saturation limits.
- **Sub-module `dc_step`:** combinational single-step filter computing y' and the saturated output from (x, x_prev, y, DCF_EN). It is instantiated once and shared between DCL and DCR by muxing the side state.

## Test plan
- **Reset:** assert RESET mid-SUM → OUT_L = OUT_R = 0, OUT_VALID = 0; no pulse follows.
- **Stereo ABC, single channel:** DCF_EN = 0, STEREO = 1, CHIP_ENA = 11, PSG0_A = 255, all other inputs 0 → OUT_L = 8160, OUT_R = 0, OUT_VALID exactly 11 CLK after the strobe.
- **Mono FM:** DCF_EN = 0, STEREO = 0, FM0 = 11'h400, others 0 → OUT_L = OUT_R = -8192.
- **Mute and saturation:**
  - Every PSG channel = 255, FM0 = FM1 = 1023, ABC, DCF_EN = 0 → OUT_L = OUT_R = 32767.
  - Same inputs with CHIP_ENA = 01 → 20424 on both sides.
- **Overrun:** strobe, then a second strobe 5 CLK later → OVERRUN pulses once and exactly one OUT_VALID occurs. A strobe at +12 CLK is accepted.
- **DC blocker:** DCF_EN = 1, constant PSG0_A = 255, ABC, strobes every 64 CLK from reset.
  - Successive OUT_L values: 8160, 8152, …, strictly decreasing toward 0.
  - OUT_R stays 0.
